// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage load/store controller: access sizes,
// FSM states, data width and the alignment check used at request accept.
package mem_ctrl_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Reserved size is treated as a misaligned request so it never reaches memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset[0];
            SIZE_WORD: return offset != 2'b00;
            SIZE_RSVD: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Little-endian lane steering: extracts and extends a loaded byte/half, and
// merges a right-aligned store byte/half into a previously read word.
module byte_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]    offset,
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data,
    output logic [DW-1:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        fill;

    always_comb begin
        lane_byte   = rdata[{offset, 3'b000} +: 8];
        lane_half   = offset[1] ? rdata[31:16] : rdata[15:0];
        fill        = 1'b0;
        load_data   = rdata;
        merged_word = rdata;

        case (size)
            SIZE_BYTE: begin
                fill        = !is_unsigned && lane_byte[7];
                load_data   = {{24{fill}}, lane_byte};
                merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                fill      = !is_unsigned && lane_half[15];
                load_data = {{16{fill}}, lane_half};
                if (offset[1]) begin
                    merged_word[31:16] = wdata[15:0];
                end else begin
                    merged_word[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data   = rdata;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MIPS MEM stage and a word-wide data memory
// without byte enables; sub-word stores are performed as read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_AW = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_rdata,
    output logic              resp_misaligned,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    state_e        state, state_n;
    logic          lat_write;
    logic          lat_unsigned;
    logic [1:0]    lat_size;
    logic [1:0]    lat_off;
    logic [DW-1:0] lat_wdata;
    logic          accept;
    logic          req_bad;
    logic          req_word_store;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merged_word;
    logic          unused_addr_hi;

    // Upper address bits alias away; the memory only sees the word index.
    assign unused_addr_hi = ^req_addr[DW-1:MEM_AW+2];

    // RESP also accepts so back-to-back requests pay no extra bubble.
    assign req_ready      = ((state == IDLE) || (state == RESP)) && !reset;
    assign accept         = req_valid && req_ready;
    assign req_bad        = is_misaligned(req_size, req_addr[1:0]);
    assign req_word_store = req_write && (req_size == SIZE_WORD);

    byte_lane_unit u_lanes (
        .offset      (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .rdata       (mem_rdata),
        .wdata       (lat_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, RESP: begin
                state_n = IDLE;
                if (accept) begin
                    if (req_bad) begin
                        state_n = RESP;
                    end else if (req_word_store) begin
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ:    state_n = lat_write ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its FSM cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_write       <= 1'b0;
            lat_unsigned    <= 1'b0;
            lat_size        <= 2'b00;
            lat_off         <= 2'b00;
            lat_wdata       <= '0;
            mem_addr        <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_wdata       <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            mem_read        <= (state_n == READ);
            mem_write       <= (state_n == WRITE);
            resp_valid      <= (state_n == RESP);
            resp_misaligned <= accept && req_bad;
            resp_rdata      <= ((state == READ) && !lat_write) ? load_data : '0;

            if (accept) begin
                lat_write    <= req_write;
                lat_unsigned <= req_unsigned;
                lat_size     <= req_size;
                lat_off      <= req_addr[1:0];
                lat_wdata    <= req_wdata;
                mem_addr     <= req_addr[MEM_AW+1:2];
                if (req_word_store && !req_bad) begin
                    mem_wdata <= req_wdata;
                end
            end

            if ((state == READ) && lat_write) begin
                mem_wdata <= merged_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, two hand-built
// multi-cycle sequences (reset mid-store, back-to-back) and random traffic.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int MEM_AW = 9;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_rdata, obs_waddr, obs_wdata;
    logic        obs_mis;
    int          obs_lat, obs_nread, obs_nwrite;

    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat, exp_nread, exp_nwrite;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic        mis;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    mem_access_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, level-sensitive write sampled at the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference: byte-granular memory semantics computed with masks and shifts.
    task automatic modelRequest(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d);
        int          idx, off, nbytes;
        logic [63:0] mask, word, val;
        idx        = int'(a[MEM_AW+1:2]);
        off        = int'(a[1:0]);
        exp_mis    = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp_rdata  = 32'h0;
        exp_nread  = 0;
        exp_nwrite = 0;
        exp_lat    = 1;
        if (!exp_mis) begin
            nbytes = 1 << int'(sz);
            mask   = (64'd1 << (8 * nbytes)) - 64'd1;
            word   = {32'd0, ref_mem[idx]};
            if (!w) begin
                val = (word >> (8 * off)) & mask;
                if (!u && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
                exp_rdata = val[31:0];
                exp_lat   = 2;
                exp_nread = 1;
            end else begin
                word = (word & ~(mask << (8 * off))) | (({32'd0, d} & mask) << (8 * off));
                ref_mem[idx] = word[31:0];
                exp_lat    = (nbytes == 4) ? 2 : 3;
                exp_nread  = (nbytes == 4) ? 0 : 1;
                exp_nwrite = 1;
            end
        end
    endtask

    // Entered just after a negedge; leaves at the negedge where resp_valid is seen.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] d);
        int guard;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        req_write = 1'($urandom_range(0, 1));
        obs_lat    = -1;
        obs_nread  = 0;
        obs_nwrite = 0;
        obs_rdata  = 32'hxxxx_xxxx;
        obs_mis    = 1'bx;
        obs_waddr  = 32'h0;
        obs_wdata  = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read) obs_nread++;
            if (mem_write) begin
                obs_nwrite++;
                obs_waddr = {23'd0, mem_addr};
                obs_wdata = mem_wdata;
            end
            if (resp_valid) begin
                obs_lat   = c;
                obs_rdata = resp_rdata;
                obs_mis   = resp_misaligned;
                break;
            end
        end
    endtask

    task automatic runAndCompare(input string name, input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] d);
        modelRequest(w, sz, u, a, d);
        applyStimulus(w, sz, u, a, d);
        checkOutput({name, "_rdata"}, obs_rdata, exp_rdata);
        checkOutput({name, "_mis"}, {31'd0, obs_mis}, {31'd0, exp_mis});
        checkOutput({name, "_lat"}, obs_lat, exp_lat);
        checkOutput({name, "_nread"}, obs_nread, exp_nread);
        checkOutput({name, "_nwrite"}, obs_nwrite, exp_nwrite);
        if (exp_nwrite != 0) begin
            checkOutput({name, "_waddr"}, obs_waddr, {23'd0, a[MEM_AW+1:2]});
            checkOutput({name, "_wdata"}, obs_wdata, ref_mem[a[MEM_AW+1:2]]);
        end
    endtask

    task automatic addVec(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input logic mis, input int lat);
        vec_t v;
        v.w = w; v.sz = sz; v.u = u; v.a = a; v.d = d;
        v.rdata = rd; v.mis = mis; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] bb_data;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end

        addVec(1, SIZE_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2);
        addVec(0, SIZE_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);
        addVec(1, SIZE_WORD, 0, 32'h10,  32'h11223344, 32'h0,        0, 2);
        addVec(1, SIZE_BYTE, 0, 32'h12,  32'h5A5A55AA, 32'h0,        0, 3);
        addVec(0, SIZE_WORD, 0, 32'h10,  32'h0,        32'h11AA3344, 0, 2);
        addVec(1, SIZE_WORD, 0, 32'h10,  32'h80FF7F01, 32'h0,        0, 2);
        addVec(0, SIZE_BYTE, 0, 32'h13,  32'h0,        32'hFFFFFF80, 0, 2);
        addVec(0, SIZE_BYTE, 1, 32'h13,  32'h0,        32'h00000080, 0, 2);
        addVec(0, SIZE_HALF, 0, 32'h12,  32'h0,        32'hFFFF80FF, 0, 2);
        addVec(0, SIZE_HALF, 1, 32'h10,  32'h0,        32'h00007F01, 0, 2);
        addVec(0, SIZE_WORD, 0, 32'h11,  32'h0,        32'h0,        1, 1);
        addVec(1, SIZE_HALF, 0, 32'h13,  32'h0000BEEF, 32'h0,        1, 1);
        addVec(0, SIZE_RSVD, 0, 32'h10,  32'h0,        32'h0,        1, 1);
        addVec(1, SIZE_HALF, 0, 32'h16,  32'hFFFF1234, 32'h0,        0, 3);
        addVec(0, SIZE_WORD, 0, 32'h814, 32'h0,        32'h12340000, 0, 2);
        addVec(0, SIZE_BYTE, 0, 32'h15,  32'h0,        32'h00000000, 0, 2);
        addVec(0, SIZE_HALF, 0, 32'h16,  32'h0,        32'h00001234, 0, 2);

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset_resp_mis", {31'd0, resp_misaligned}, 32'd0);
        checkOutput("reset_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        checkOutput("reset_mem_addr", {23'd0, mem_addr}, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", {31'd0, req_ready}, 32'd1);

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            runAndCompare($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d);
            checkOutput($sformatf("vec%0d_tbl_rdata", i), obs_rdata, vecs[i].rdata);
            checkOutput($sformatf("vec%0d_tbl_mis", i), {31'd0, obs_mis}, {31'd0, vecs[i].mis});
            checkOutput($sformatf("vec%0d_tbl_lat", i), obs_lat, vecs[i].lat);
        end

        $display("[TB] reset during the READ cycle of a half store");
        runAndCompare("rst_prep", 1, SIZE_WORD, 0, 32'h18, 32'hCAFEF00D);
        req_write    = 1'b1;
        req_size     = SIZE_HALF;
        req_unsigned = 1'b0;
        req_addr     = 32'h1A;
        req_wdata    = 32'h00005555;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_read", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
        checkOutput("rst_mem_read", {31'd0, mem_read}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready_back", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_quiet", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_word_kept", mem[6], 32'hCAFEF00D);
        runAndCompare("rst_reload", 0, SIZE_WORD, 0, 32'h18, 32'h0);

        $display("[TB] back-to-back store then load with req_valid held");
        bb_data = 32'h5A5AC3C3;
        modelRequest(1, SIZE_WORD, 0, 32'h20, bb_data);
        req_write = 1'b1;
        req_size  = SIZE_WORD;
        req_addr  = 32'h20;
        req_wdata = bb_data;
        req_valid = 1'b1;
        checkOutput("b2b_first_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_wdata = 32'h0;
        @(negedge clk);
        checkOutput("b2b_write_cycle", {30'd0, mem_write, req_ready}, 32'd2);
        @(negedge clk);
        checkOutput("b2b_resp_and_ready", {30'd0, resp_valid, req_ready}, 32'd3);
        modelRequest(0, SIZE_WORD, 0, 32'h20, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_load_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        checkOutput("b2b_load_resp", {31'd0, resp_valid}, 32'd1);
        checkOutput("b2b_load_data", resp_rdata, exp_rdata);
        checkOutput("b2b_load_const", resp_rdata, bb_data);

        $display("[TB] randomized traffic against the reference model");
        for (int i = 0; i < 200; i++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] a, d;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom() & 32'hFFFF_F800) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom();
            runAndCompare($sformatf("rnd%0d", i), w, sz, u, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
